// File: rtl/pixel_stream_tx.sv
// pixel_stream_tx: raster-order frame-buffer reader feeding the window shift chain.
// Reads an IMG_W x IMG_H 8-bit image from a 1-cycle-latency synchronous RAM.
// It emits one pixel per load pulse and inserts GAP idle cycles between lines.
// Boundary tags travel with each pixel through a fixed 2-cycle read-to-load pipeline.
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   start               - begin a frame (accepted only when idle)
//   stall               - downstream back-pressure; blocks new reads only
//   mem_en, mem_addr    - RAM read request (raster address from 0)
//   mem_data            - RAM read data, valid the cycle after mem_en
//   data, load          - pixel and its valid strobe
//   line_last           - with load on the last pixel of each line
//   frame_done          - with load on the final pixel of the frame
//   busy                - from start acceptance through the frame_done cycle
module pixel_stream_tx #(
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 480,
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned GAP    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic [7:0]        data,
  output logic              load,
  output logic              line_last,
  output logic              frame_done,
  output logic              busy
);

  localparam int unsigned COL_W    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int unsigned GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_GAP, S_DRAIN} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [COL_W-1:0]    r_col;
  logic [ROW_W-1:0]    r_row;
  logic [GAP_W-1:0]    r_gap;
  logic                w_issue;
  logic                w_eol;
  logic                w_eof;
  // Stage 1: read in flight (RAM is producing data); tags captured at issue.
  logic                r_v1;
  logic                r_last1;
  logic                r_done1;
  // Stage 2: registered pixel outputs.
  logic [7:0]          r_data;
  logic                r_load;
  logic                r_line_last;
  logic                r_frame_done;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and read-issue decode.
  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    w_eol   = 1'b0;
    w_eof   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_READ;
      end
      S_READ: begin
        if (!stall) begin
          w_issue = 1'b1;
          if (r_col == COL_W'(IMG_W - 1)) begin
            w_eol = 1'b1;
            if (r_row == ROW_W'(IMG_H - 1)) begin
              w_eof  = 1'b1;
              w_next = S_DRAIN;
            end else if (GAP > 0) begin
              w_next = S_GAP;
            end
          end
        end
      end
      S_GAP: begin
        if (r_gap == GAP_W'(GAP_LAST)) w_next = S_READ;
      end
      S_DRAIN: begin
        // Leave once the final pixel is on the outputs, keeping busy high that cycle.
        if (r_frame_done) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Raster counters; addr is a plain incrementer cleared at frame start.
  always_ff @(posedge clk) begin
    if (reset || (r_state == S_IDLE && start)) begin
      r_addr <= '0;
      r_col  <= '0;
      r_row  <= '0;
    end else if (w_issue) begin
      r_addr <= r_addr + ADDR_W'(1);
      if (w_eol) begin
        r_col <= '0;
        r_row <= r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // Inter-line gap counter; stall does not extend it.
  always_ff @(posedge clk) begin
    if (reset || r_state != S_GAP) r_gap <= '0;
    else                          r_gap <= r_gap + GAP_W'(1);
  end

  // Read-to-load pipeline; an issued read always completes unless reset discards it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1         <= 1'b0;
      r_last1      <= 1'b0;
      r_done1      <= 1'b0;
      r_data       <= '0;
      r_load       <= 1'b0;
      r_line_last  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_v1         <= w_issue;
      r_last1      <= w_eol;
      r_done1      <= w_eof;
      r_load       <= r_v1;
      r_line_last  <= r_v1 & r_last1;
      r_frame_done <= r_v1 & r_done1;
      if (r_v1) r_data <= mem_data;
    end
  end

  assign mem_en     = w_issue;
  assign mem_addr   = r_addr;
  assign data       = r_data;
  assign load       = r_load;
  assign line_last  = r_line_last;
  assign frame_done = r_frame_done;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Bench for pixel_stream_tx: cycle tables for a 4x3/GAP=2 instance (with stall and
// back-to-back frames) and a 2x2/GAP=0 instance, plus sequences for reset abort
// and start-while-busy.
module tb_pixel_stream_tx;

  typedef struct {
    logic       start;
    logic       stall;
    logic       en;
    logic [3:0] addr;
    logic       ld;
    logic [7:0] d;
    logic       ll;
    logic       fd;
    logic       bz;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_start, a_stall, a_mem_en, a_load, a_ll, a_fd, a_busy;
  logic [3:0] a_mem_addr;
  logic [7:0] a_mem_data, a_data;
  logic       b_start, b_stall, b_mem_en, b_load, b_ll, b_fd, b_busy;
  logic [3:0] b_mem_addr;
  logic [7:0] b_mem_data, b_data;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t tA[42];
  vec_t tB[8];

  always #5 clk = ~clk;

  pixel_stream_tx #(.IMG_W(4), .IMG_H(3), .ADDR_W(4), .GAP(2)) u_a (
    .clk(clk), .reset(reset), .start(a_start), .stall(a_stall),
    .mem_en(a_mem_en), .mem_addr(a_mem_addr), .mem_data(a_mem_data),
    .data(a_data), .load(a_load), .line_last(a_ll), .frame_done(a_fd), .busy(a_busy));

  pixel_stream_tx #(.IMG_W(2), .IMG_H(2), .ADDR_W(4), .GAP(0)) u_b (
    .clk(clk), .reset(reset), .start(b_start), .stall(b_stall),
    .mem_en(b_mem_en), .mem_addr(b_mem_addr), .mem_data(b_mem_data),
    .data(b_data), .load(b_load), .line_last(b_ll), .frame_done(b_fd), .busy(b_busy));

  // RAM models: RAM[i] = i, one cycle read latency.
  always @(posedge clk) begin
    if (a_mem_en) a_mem_data <= 8'(a_mem_addr);
    if (b_mem_en) b_mem_data <= 8'(b_mem_addr);
  end

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t V(input int st, input int sl, input int en, input int ad,
                             input int ld, input int d, input int ll, input int fd, input int bz);
    vec_t v;
    v.start = 1'(st); v.stall = 1'(sl); v.en = 1'(en); v.addr = 4'(ad);
    v.ld = 1'(ld); v.d = 8'(d); v.ll = 1'(ll); v.fd = 1'(fd); v.bz = 1'(bz);
    return v;
  endfunction

  task automatic check_row(input string tag, input int i, input vec_t v,
                           input logic en, input logic [3:0] addr, input logic ld,
                           input logic [7:0] d, input logic ll, input logic fd, input logic bz);
    chk({tag, "_mem_en"}, i, 32'(en), 32'(v.en));
    if (v.en) chk({tag, "_mem_addr"}, i, 32'(addr), 32'(v.addr));
    chk({tag, "_load"}, i, 32'(ld), 32'(v.ld));
    chk({tag, "_data"}, i, 32'(d), 32'(v.d));
    chk({tag, "_line_last"}, i, 32'(ll), 32'(v.ll));
    chk({tag, "_frame_done"}, i, 32'(fd), 32'(v.fd));
    chk({tag, "_busy"}, i, 32'(bz), 32'(v.bz));
  endtask

  // One 4x3 frame on instance A; optionally pulses start again while addr 2 issues.
  task automatic run_frame(input string tag, input bit poke);
    int nload = 0;
    int nfd   = 0;
    bit first_seen = 1'b0;
    bit pend  = 1'b0;
    bit poked = 1'b0;
    a_start = 1'b1;
    @(posedge clk); #1;
    for (int t = 0; t < 30; t++) begin
      a_start = pend;
      pend = 1'b0;
      @(negedge clk);
      if (a_mem_en && !first_seen) begin
        first_seen = 1'b1;
        chk({tag, "_first_addr"}, t, 32'(a_mem_addr), 32'd0);
      end
      if (poke && !poked && a_mem_en && a_mem_addr == 4'd2) begin
        pend  = 1'b1;
        poked = 1'b1;
      end
      if (a_load) begin
        chk({tag, "_data"}, nload, 32'(a_data), 32'(nload));
        chk({tag, "_line_last"}, nload, 32'(a_ll), 32'((nload % 4) == 3));
        chk({tag, "_frame_done"}, nload, 32'(a_fd), 32'(nload == 11));
        nload++;
      end else if (a_fd) begin
        chk({tag, "_fd_without_load"}, t, 32'(a_load), 32'd1);
      end
      if (a_fd) nfd++;
      @(posedge clk); #1;
    end
    a_start = 1'b0;
    chk({tag, "_saw_read"}, 0, 32'(first_seen), 32'd1);
    chk({tag, "_pixels"}, 0, 32'(nload), 32'd12);
    chk({tag, "_frame_done_cnt"}, 0, 32'(nfd), 32'd1);
    chk({tag, "_busy_after"}, 0, 32'(a_busy), 32'd0);
  endtask

  initial begin
    bit found;
    reset = 1'b1;
    a_start = 1'b0; a_stall = 1'b0;
    b_start = 1'b0; b_stall = 1'b0;

    // Columns: start, stall, mem_en, mem_addr, load, data, line_last, frame_done, busy.
    // Frame 1: no stall.
    tA[0]  = V(1,0,0, 0,0, 0,0,0,0);
    tA[1]  = V(0,0,1, 0,0, 0,0,0,1);
    tA[2]  = V(0,0,1, 1,0, 0,0,0,1);
    tA[3]  = V(0,0,1, 2,1, 0,0,0,1);
    tA[4]  = V(0,0,1, 3,1, 1,0,0,1);
    tA[5]  = V(0,0,0, 0,1, 2,0,0,1);
    tA[6]  = V(0,0,0, 0,1, 3,1,0,1);
    tA[7]  = V(0,0,1, 4,0, 3,0,0,1);
    tA[8]  = V(0,0,1, 5,0, 3,0,0,1);
    tA[9]  = V(0,0,1, 6,1, 4,0,0,1);
    tA[10] = V(0,0,1, 7,1, 5,0,0,1);
    tA[11] = V(0,0,0, 0,1, 6,0,0,1);
    tA[12] = V(0,0,0, 0,1, 7,1,0,1);
    tA[13] = V(0,0,1, 8,0, 7,0,0,1);
    tA[14] = V(0,0,1, 9,0, 7,0,0,1);
    tA[15] = V(0,0,1,10,1, 8,0,0,1);
    tA[16] = V(0,0,1,11,1, 9,0,0,1);
    tA[17] = V(0,0,0, 0,1,10,0,0,1);
    tA[18] = V(0,0,0, 0,1,11,1,1,1);
    // Frame 2: started the cycle after frame_done, stall for 3 cycles before addr 5.
    tA[19] = V(1,0,0, 0,0,11,0,0,0);
    tA[20] = V(0,0,1, 0,0,11,0,0,1);
    tA[21] = V(0,0,1, 1,0,11,0,0,1);
    tA[22] = V(0,0,1, 2,1, 0,0,0,1);
    tA[23] = V(0,0,1, 3,1, 1,0,0,1);
    tA[24] = V(0,0,0, 0,1, 2,0,0,1);
    tA[25] = V(0,0,0, 0,1, 3,1,0,1);
    tA[26] = V(0,0,1, 4,0, 3,0,0,1);
    tA[27] = V(0,1,0, 0,0, 3,0,0,1);
    tA[28] = V(0,1,0, 0,1, 4,0,0,1);
    tA[29] = V(0,1,0, 0,0, 4,0,0,1);
    tA[30] = V(0,0,1, 5,0, 4,0,0,1);
    tA[31] = V(0,0,1, 6,0, 4,0,0,1);
    tA[32] = V(0,0,1, 7,1, 5,0,0,1);
    tA[33] = V(0,0,0, 0,1, 6,0,0,1);
    tA[34] = V(0,0,0, 0,1, 7,1,0,1);
    tA[35] = V(0,0,1, 8,0, 7,0,0,1);
    tA[36] = V(0,0,1, 9,0, 7,0,0,1);
    tA[37] = V(0,0,1,10,1, 8,0,0,1);
    tA[38] = V(0,0,1,11,1, 9,0,0,1);
    tA[39] = V(0,0,0, 0,1,10,0,0,1);
    tA[40] = V(0,0,0, 0,1,11,1,1,1);
    tA[41] = V(0,0,0, 0,0,11,0,0,0);

    // 2x2, GAP=0: four back-to-back reads and loads.
    tB[0] = V(1,0,0,0,0,0,0,0,0);
    tB[1] = V(0,0,1,0,0,0,0,0,1);
    tB[2] = V(0,0,1,1,0,0,0,0,1);
    tB[3] = V(0,0,1,2,1,0,0,0,1);
    tB[4] = V(0,0,1,3,1,1,1,0,1);
    tB[5] = V(0,0,0,0,1,2,0,0,1);
    tB[6] = V(0,0,0,0,1,3,1,1,1);
    tB[7] = V(0,0,0,0,0,3,0,0,0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_mem_en", 0, 32'(a_mem_en), 32'd0);
    chk("rst_load", 0, 32'(a_load), 32'd0);
    chk("rst_data", 0, 32'(a_data), 32'd0);
    chk("rst_line_last", 0, 32'(a_ll), 32'd0);
    chk("rst_frame_done", 0, 32'(a_fd), 32'd0);
    chk("rst_busy", 0, 32'(a_busy), 32'd0);
    chk("rst_b_busy", 0, 32'(b_busy), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 42; i++) begin
      a_start = tA[i].start;
      a_stall = tA[i].stall;
      @(negedge clk);
      check_row("A", i, tA[i], a_mem_en, a_mem_addr, a_load, a_data, a_ll, a_fd, a_busy);
      @(posedge clk); #1;
    end
    a_start = 1'b0; a_stall = 1'b0;

    for (int i = 0; i < 8; i++) begin
      b_start = tB[i].start;
      b_stall = tB[i].stall;
      @(negedge clk);
      check_row("B", i, tB[i], b_mem_en, b_mem_addr, b_load, b_data, b_ll, b_fd, b_busy);
      @(posedge clk); #1;
    end
    b_start = 1'b0;

    // Reset while addr 6 is issuing aborts the frame.
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (a_mem_en && a_mem_addr == 4'd6) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("abort_reach_addr6", 0, 32'(found), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_mem_en", 0, 32'(a_mem_en), 32'd0);
    chk("abort_load", 0, 32'(a_load), 32'd0);
    chk("abort_data", 0, 32'(a_data), 32'd0);
    chk("abort_line_last", 0, 32'(a_ll), 32'd0);
    chk("abort_frame_done", 0, 32'(a_fd), 32'd0);
    chk("abort_busy", 0, 32'(a_busy), 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort_quiet_load", k, 32'(a_load), 32'd0);
      chk("abort_quiet_fd", k, 32'(a_fd), 32'd0);
    end
    @(posedge clk); #1;

    run_frame("restart", 1'b0);
    run_frame("busy_start", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_stream_tx.md
Name: pixel_stream_tx

Overview:
- Frame-buffer reader that drives the pixel stream (data + load strobe) consumed by the window shift-register chain in the feature-detection front end.
- On `start`, scans an IMG_W x IMG_H 8-bit image in raster order from a 1-cycle-latency synchronous RAM.
- Emits one pixel per load pulse, inserts GAP idle cycles between lines, honours downstream stall, and flags line/frame boundaries.

Parameters:
- IMG_W, 640, pixels per line (>=2)
- IMG_H, 480, lines per frame (>=1)
- ADDR_W, 19, RAM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- GAP, 4, idle cycles inserted between lines (>=0)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a frame; sampled only in IDLE
- stall  in  1  downstream back-pressure; blocks new reads
- mem_en  out  1  RAM read enable
- mem_addr  out  ADDR_W  RAM read address, raster order from 0
- mem_data  in  8  RAM read data, valid the cycle after mem_en
- data  out  8  pixel to shift chain
- load  out  1  data valid strobe, one pixel per high cycle
- line_last  out  1  high with load on the last pixel of each line
- frame_done  out  1  one-cycle pulse with load on the final pixel
- busy  out  1  high from start acceptance until frame_done cycle inclusive

Behaviour:
- Reset (synchronous, active-high; `clk` and `reset` are the clock and reset port names):
  - all outputs 0; FSM to IDLE; col, row and addr counters 0.
  - Reset mid-frame aborts the frame; no frame_done; the in-flight read is discarded.
- FSM states: IDLE, READ, GAP, DRAIN.
  - IDLE: start=1 -> READ, busy=1 from next cycle. start outside IDLE is ignored.
  - READ: each cycle with stall=0, assert mem_en with mem_addr=addr, then increment addr and col.
    - stall=1: mem_en=0 and counters hold.
    - After issuing col=IMG_W-1: col<=0, row+1.
    - If that was the last row -> DRAIN; else -> GAP if GAP>0, else stay in READ.
  - GAP: count GAP cycles with mem_en=0 -> READ. stall does not extend GAP; READ re-checks stall.
  - DRAIN: wait for the final read to emerge.
    - frame_done=1 and load=1 in the same cycle; busy stays 1 that cycle, then IDLE.
- Output pipeline and latency:
  - mem_en high in cycle N -> mem_data sampled at end of N+1 -> data/load registered, visible in cycle N+2. Fixed 2-cycle read-to-load latency.
  - A read already issued always produces its load pulse, even if stall rises meanwhile. Downstream tolerates one trailing pixel per stall assertion.
  - load=0 cycles: data holds last value.
  - line_last and frame_done are tagged at issue time and travel with the pixel through the same 2 pipeline stages.
- Addressing: addr is an incrementing counter (no multiplier), range 0..IMG_W*IMG_H-1, never wraps within a frame. It is reset to 0 at frame start.
- Throughput: with stall=0, exactly IMG_W consecutive load cycles per line, then GAP load-free cycles. Frame length from start to frame_done is IMG_H*IMG_W + (IMG_H-1)*GAP + 2 cycles, counting from the first READ cycle.
- Simultaneous events:
  - start with reset: reset wins.
  - stall on the cycle the last pixel would issue: issue waits; the DRAIN transition occurs only after the actual issue.
  - start on the cycle after frame_done (IDLE) is accepted.

Test Plan:
- IMG_W=4, IMG_H=3, GAP=2, RAM[i]=i, stall=0, pulse start:
  - mem_addr 0..11 issued in bursts of 4 separated by 2 idle cycles.
  - load/data sequence 0..11, each 2 cycles after its mem_en.
  - line_last on pixels 3, 7, 11; frame_done single pulse with data=11; total length 12+4+2 cycles.
- Same config, stall=1 for 3 cycles starting when addr=5 is about to issue:
  - pixel 4 (already issued) still loads.
  - No mem_en for 3 cycles, then addr 5 resumes.
  - Output data order unbroken 0..11.
- Reset asserted while addr=6 mid-frame:
  - next cycle all outputs 0, busy=0, no frame_done.
  - A following start re-reads from addr 0.
- start pulsed while busy (at addr 2): ignored; exactly one frame of 12 pixels and one frame_done.
- GAP=0, IMG_W=2, IMG_H=2: four back-to-back load cycles 0,1,2,3; line_last on 1 and 3; frame_done with 3.
- Back-to-back frames (start the cycle after frame_done): second frame begins at addr 0 with identical output sequence.
